// File: rtl/mfp_seven_seg_pkg.sv
// Shared constants for the seven-segment display family: segment bit positions,
// the hex-to-segment table and small sizing helpers.
package mfp_seven_seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [7:0] seg_byte(input logic dp, input logic [6:0] seg);
        logic [7:0] b;
        b               = '0;
        b[SEG_G:SEG_A]  = seg;
        b[SEG_DP]       = dp;
        return b;
    endfunction

endpackage

// File: rtl/mfp_seven_seg_scan_timer.sv
// Scan timing: free-running prescaler, digit index, frame-wrap pulse and PWM phase.
module mfp_seven_seg_scan_timer
    import mfp_seven_seg_pkg::*;
#(
    parameter  int N_DIGITS   = 8,
    parameter  int DWELL_LOG2 = 14,
    parameter  int PWM_W      = 4,
    localparam int IDX_W      = idx_width(N_DIGITS)
)
(
    input  logic                  HCLK,
    input  logic                  HRESETn,
    output logic [DWELL_LOG2-1:0] pre,
    output logic [IDX_W-1:0]      idx,
    output logic [PWM_W-1:0]      pwm,
    output logic                  frame_tick
);

    logic pre_max;
    logic wrap;

    assign pre_max = &pre;
    assign wrap    = pre_max && (idx == IDX_W'(N_DIGITS - 1));
    assign pwm     = pre[DWELL_LOG2-1 -: PWM_W];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pre        <= '0;
            idx        <= '0;
            frame_tick <= 1'b0;
        end else begin
            pre        <= pre + DWELL_LOG2'(1);
            frame_tick <= wrap;
            if (pre_max) begin
                idx <= wrap ? '0 : idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/mfp_single_digit_seven_segment_display.sv
// Combinational hex-to-segment decoder for one digit, active-high {g..a}.
module mfp_single_digit_seven_segment_display
    import mfp_seven_seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[digit];

endmodule

// File: rtl/mfp_multi_digit_seven_segment_display.sv
// N-digit seven-segment driver: staged capture, frame-boundary transfer, static
// and scanned outputs with leading-zero blanking and PWM brightness.
module mfp_multi_digit_seven_segment_display
    import mfp_seven_seg_pkg::*;
#(
    parameter int N_DIGITS   = 8,
    parameter int DWELL_LOG2 = 14,
    parameter int PWM_W      = 4,
    parameter int ACTIVE_LOW = 1
)
(
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dot,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic [PWM_W-1:0]      brightness,
    output logic [8*N_DIGITS-1:0] seg_static,
    output logic [7:0]            seg_mux,
    output logic [N_DIGITS-1:0]   anode,
    output logic                  frame_tick
);

    localparam int                  IDX_W     = idx_width(N_DIGITS);
    localparam logic [7:0]          SEG_OFF   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] ANODE_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [4*N_DIGITS-1:0] stg_val, dsp_val;
    logic [N_DIGITS-1:0]   stg_dot, dsp_dot;
    logic [N_DIGITS-1:0]   stg_en,  dsp_en;
    logic                  pending;

    logic [DWELL_LOG2-1:0] pre;
    logic [IDX_W-1:0]      idx;
    logic [PWM_W-1:0]      pwm;

    mfp_seven_seg_scan_timer #(
        .N_DIGITS   (N_DIGITS),
        .DWELL_LOG2 (DWELL_LOG2),
        .PWM_W      (PWM_W)
    ) u_timer (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .pre        (pre),
        .idx        (idx),
        .pwm        (pwm),
        .frame_tick (frame_tick)
    );

    // NOTE: staging and display registers are reset explicitly, so a reset
    // mid-frame also throws away any pending load.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            stg_val <= '0;
            stg_dot <= '0;
            stg_en  <= '0;
            dsp_val <= '0;
            dsp_dot <= '0;
            dsp_en  <= '0;
            pending <= 1'b0;
        end else begin
            if (load) begin
                stg_val <= value;
                stg_dot <= dot;
                stg_en  <= digit_en;
            end
            // Display content only moves at frame_tick, and that first cycle of
            // the new frame is hidden by the pre==0 ghost guard.
            if (frame_tick) begin
                pending <= 1'b0;
                if (load) begin
                    dsp_val <= value;
                    dsp_dot <= dot;
                    dsp_en  <= digit_en;
                end else if (pending) begin
                    dsp_val <= stg_val;
                    dsp_dot <= stg_dot;
                    dsp_en  <= stg_en;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    logic [6:0] dig_seg [N_DIGITS];

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_static_dec
        mfp_single_digit_seven_segment_display u_dec (
            .digit (dsp_val[4*g +: 4]),
            .seg   (dig_seg[g])
        );
    end

    logic [N_DIGITS-1:0] visible;
    logic                run_zero;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        run_zero = 1'b1;
        visible  = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run_zero   = run_zero && (dsp_val[4*i +: 4] == 4'h0) && !dsp_dot[i];
            visible[i] = dsp_en[i] && !(blank_lz && run_zero && (i != 0));
        end
    end

    logic [3:0] mux_nibble;
    logic       mux_dot;
    logic       mux_vis;
    logic [6:0] mux_seg;

    always_comb begin
        mux_nibble = '0;
        mux_dot    = 1'b0;
        mux_vis    = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                mux_nibble = dsp_val[4*i +: 4];
                mux_dot    = dsp_dot[i];
                mux_vis    = visible[i];
            end
        end
    end

    mfp_single_digit_seven_segment_display u_mux_dec (
        .digit (mux_nibble),
        .seg   (mux_seg)
    );

    logic [8*N_DIGITS-1:0] static_next;
    logic [7:0]            mux_next;
    logic [N_DIGITS-1:0]   anode_next;
    logic                  pwm_on;

    assign pwm_on = (pwm < brightness) || (&brightness);

    always_comb begin
        static_next = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            static_next[8*i +: 8] =
                (visible[i] ? seg_byte(dsp_dot[i], dig_seg[i]) : 8'h00) ^ SEG_OFF;
        end
        mux_next   = (mux_vis ? seg_byte(mux_dot, mux_seg) : 8'h00) ^ SEG_OFF;
        anode_next = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                anode_next[i] = mux_vis && (pre != '0) && pwm_on;
            end
        end
        anode_next = anode_next ^ ANODE_OFF;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            seg_static <= {N_DIGITS{SEG_OFF}};
            seg_mux    <= SEG_OFF;
            anode      <= ANODE_OFF;
        end else begin
            seg_static <= static_next;
            seg_mux    <= mux_next;
            anode      <= anode_next;
        end
    end

endmodule

// File: tb/tb_mfp_multi_digit_seven_segment_display.sv
// Scoreboard bench: a cycle-count reference model predicts every output cycle,
// a negedge monitor compares; directed checks cover the documented scenarios.
module tb_mfp_multi_digit_seven_segment_display;

    localparam int N  = 4;
    localparam int DL = 4;
    localparam int PW = 2;
    localparam int DW = 1 << DL;

    localparam logic [6:0] HEX7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef logic [8*N+8+N:0] obs_t;
    localparam obs_t RESET_OBS = {{(8*N){1'b1}}, 8'hFF, {N{1'b1}}, 1'b0};

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic [4*N-1:0]    value;
    logic [N-1:0]      dot;
    logic [N-1:0]      digit_en;
    logic              load;
    logic              blank_lz;
    logic [PW-1:0]     brightness;
    logic [8*N-1:0]    seg_static;
    logic [7:0]        seg_mux;
    logic [N-1:0]      anode;
    logic              frame_tick;

    mfp_multi_digit_seven_segment_display #(
        .N_DIGITS   (N),
        .DWELL_LOG2 (DL),
        .PWM_W      (PW),
        .ACTIVE_LOW (1)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .value      (value),
        .dot        (dot),
        .digit_en   (digit_en),
        .load       (load),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .seg_static (seg_static),
        .seg_mux    (seg_mux),
        .anode      (anode),
        .frame_tick (frame_tick)
    );

    always #5 HCLK = ~HCLK;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int   cyc;
    bit   m_ft, m_pend;
    int   m_stg_v [N];
    bit   m_stg_d [N], m_stg_e [N];
    int   m_dsp_v [N];
    bit   m_dsp_d [N], m_dsp_e [N];
    obs_t exp_q [$];

    function automatic bit visible(input int i, input bit lz);
        if (!m_dsp_e[i]) return 1'b0;
        if (!lz || i == 0) return 1'b1;
        for (int j = i; j < N; j++)
            if (m_dsp_v[j] != 0 || m_dsp_d[j]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] seg_of(input int i, input bit lz);
        if (!visible(i, lz)) return 8'hFF;
        return ~{m_dsp_d[i], HEX7[m_dsp_v[i]]};
    endfunction

    function automatic obs_t model_out(input bit lz, input int br);
        int             pre, idx, pwm;
        logic [8*N-1:0] s;
        logic [N-1:0]   a;
        pre = cyc % DW;
        idx = (cyc / DW) % N;
        pwm = pre / (DW >> PW);
        for (int i = 0; i < N; i++) s[8*i +: 8] = seg_of(i, lz);
        a = '1;
        if (visible(idx, lz) && pre != 0 && (pwm < br || br == (1 << PW) - 1)) a[idx] = 1'b0;
        return {s, seg_of(idx, lz), a, (pre == DW - 1) && (idx == N - 1)};
    endfunction

    task automatic model_reset();
        cyc    = 0;
        m_ft   = 1'b0;
        m_pend = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_stg_v[i] = 0; m_stg_d[i] = 0; m_stg_e[i] = 0;
            m_dsp_v[i] = 0; m_dsp_d[i] = 0; m_dsp_e[i] = 0;
        end
        exp_q.delete();
        exp_q.push_back(RESET_OBS);
    endtask

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            model_reset();
        end else begin
            exp_q.push_back(model_out(blank_lz, int'(brightness)));
            if (m_ft) begin
                if (load) begin
                    for (int i = 0; i < N; i++) begin
                        m_dsp_v[i] = int'(value[4*i +: 4]);
                        m_dsp_d[i] = dot[i];
                        m_dsp_e[i] = digit_en[i];
                    end
                end else if (m_pend) begin
                    m_dsp_v = m_stg_v;
                    m_dsp_d = m_stg_d;
                    m_dsp_e = m_stg_e;
                end
                m_pend = 1'b0;
            end else if (load) begin
                m_pend = 1'b1;
            end
            if (load) begin
                for (int i = 0; i < N; i++) begin
                    m_stg_v[i] = int'(value[4*i +: 4]);
                    m_stg_d[i] = dot[i];
                    m_stg_e[i] = digit_en[i];
                end
            end
            m_ft = ((cyc % DW) == DW - 1) && (((cyc / DW) % N) == N - 1);
            cyc++;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge HCLK) begin
        obs_t got;
        obs_t e;
        got = {seg_static, seg_mux, anode, frame_tick};
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check("outputs", 64'(got), 64'(e));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge HCLK);
        #2;
    endtask

    task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] d, input logic [N-1:0] e);
        value    = v;
        dot      = d;
        digit_en = e;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic wait_ft();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_tick && n < 200);
        if (!frame_tick) check("frame_tick_timeout", 64'd0, 64'd1);
    endtask

    task automatic release_and_time(input string name);
        int n;
        HRESETn = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_tick && n < 200);
        check(name, 64'(n), 64'(N * DW));
    endtask

    task automatic count_on(input logic [PW-1:0] br, input int exp_cnt, input string name);
        int cnt;
        brightness = br;
        cnt = 0;
        for (int k = 0; k < N * DW; k++) begin
            tick();
            if (anode != {N{1'b1}}) cnt++;
        end
        check(name, 64'(cnt), 64'(exp_cnt));
    endtask

    initial begin
        HRESETn    = 1'b0;
        value      = '0;
        dot        = '0;
        digit_en   = '0;
        load       = 1'b0;
        blank_lz   = 1'b0;
        brightness = '1;
        repeat (3) tick();
        check("rst_anode", 64'(anode), 64'hF);
        check("rst_seg_mux", 64'(seg_mux), 64'hFF);
        check("rst_seg_static", 64'(seg_static), 64'hFFFF_FFFF);
        release_and_time("first_frame_tick");

        // Frame-boundary update
        repeat (20) tick();
        do_load(16'h12AF, 4'h0, 4'hF);
        wait_ft();
        repeat (2) tick();
        check("boundary_12AF", 64'(seg_static), 64'hF9A4_888E);

        // Leading-zero blanking
        blank_lz = 1'b1;
        repeat (7) tick();
        do_load(16'h0050, 4'h0, 4'hF);
        wait_ft();
        repeat (2) tick();
        check("lz_0050", 64'(seg_static), 64'hFFFF_92C0);
        do_load(16'h0050, 4'b1000, 4'hF);
        wait_ft();
        repeat (2) tick();
        check("lz_dot3", 64'(seg_static), 64'h40C0_92C0);

        // Brightness duty per frame (all four digits visible)
        do_load(16'h1234, 4'h0, 4'hF);
        wait_ft();
        repeat (2) tick();
        count_on(2'b01, 3 * N, "duty_br1");
        count_on(2'b11, 15 * N, "duty_br3");
        count_on(2'b00, 0, "duty_br0");
        count_on(2'b10, 7 * N, "duty_br2");
        brightness = 2'b11;

        // Back-to-back loads, then a load coincident with frame_tick
        wait_ft();
        repeat (10) tick();
        do_load(16'h1111, 4'h0, 4'hF);
        repeat (3) tick();
        do_load(16'h2222, 4'h0, 4'hF);
        wait_ft();
        repeat (2) tick();
        check("b2b_2222", 64'(seg_static), 64'hA4A4_A4A4);
        wait_ft();
        do_load(16'h3333, 4'h0, 4'hF);
        tick();
        check("bypass_3333", 64'(seg_static), 64'hB0B0_B0B0);

        // Reset mid-operation with a pending load
        repeat (12) tick();
        do_load(16'h9999, 4'hF, 4'hF);
        repeat (3) tick();
        HRESETn = 1'b0;
        #1;
        check("mid_rst_anode", 64'(anode), 64'hF);
        check("mid_rst_seg_mux", 64'(seg_mux), 64'hFF);
        check("mid_rst_seg_static", 64'(seg_static), 64'hFFFF_FFFF);
        check("mid_rst_frame_tick", 64'(frame_tick), 64'd0);
        tick();
        release_and_time("frame_tick_after_rst");
        repeat (2) tick();
        check("pending_discarded", 64'(seg_static), 64'hFFFF_FFFF);

        // Randomized traffic checked by the scoreboard
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                logic [4*N-1:0] v;
                v = 16'($urandom) & 16'((1 << (4 * $urandom_range(1, 4))) - 1);
                do_load(v,
                        ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
                        ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF);
            end else begin
                tick();
            end
            if ($urandom_range(0, 63) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 63) == 0) brightness = 2'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                HRESETn = 1'b0;
                tick();
                HRESETn = 1'b1;
            end
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
